// File: rtl/ext_int_controller_pkg.sv
// Shared encodings for the external interrupt controller: trigger modes,
// register offsets and FSM states.
package ext_int_controller_pkg;

    typedef enum logic [1:0] {
        MODE_LOW  = 2'b00,
        MODE_ANY  = 2'b01,
        MODE_FALL = 2'b10,
        MODE_RISE = 2'b11
    } mode_e;

    localparam logic [7:0] OFF_EICRA = 8'h0;
    localparam logic [7:0] OFF_EIFR  = 8'h4;
    localparam logic [7:0] OFF_EIMSK = 8'h8;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'b00,
        ST_REQUEST    = 2'b01,
        ST_IN_SERVICE = 2'b10
    } state_e;

    function automatic logic edge_match(input mode_e mode, input logic rise, input logic fall);
        case (mode)
            MODE_ANY:  edge_match = rise | fall;
            MODE_FALL: edge_match = fall;
            MODE_RISE: edge_match = rise;
            default:   edge_match = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ext_int_controller_pin_filter.sv
// Per-pin input path: 2-flop synchroniser, stability filter and edge detect.
module int_pin_filter #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic pin,
    output logic filtered,
    output logic rise,
    output logic fall
);

    logic sync1;
    logic sync2;
    logic prev;
    logic filt;

    // Everything idles high so that releasing reset with pins pulled up yields no edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
            prev  <= filt;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign filt = sync2;
        end else begin : g_debounce
            localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
            logic [CW-1:0] count;

            always_ff @(posedge clock) begin
                if (reset) begin
                    filt  <= 1'b1;
                    count <= '0;
                end else if (sync2 != filt) begin
                    if (count == CW'(DEBOUNCE_CYCLES - 1)) begin
                        filt  <= sync2;
                        count <= '0;
                    end else begin
                        count <= count + CW'(1);
                    end
                end else begin
                    count <= '0;
                end
            end
        end
    endgenerate

    assign filtered = filt;
    assign rise     = filt & ~prev;
    assign fall     = ~filt & prev;

endmodule

// File: rtl/ext_int_controller.sv
// External interrupt controller: filtered pins, EICRA/EIFR/EIMSK registers
// and a single-level request/ack/done handshake to the interrupt handler.
module ext_int_controller
    import ext_int_controller_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS    = 2,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned ADDRESS_BITS    = 32,
    parameter logic [ADDRESS_BITS-1:0] BASE_ADDRESS = ADDRESS_BITS'(32'h0000_206C),
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_CHANNELS-1:0] pin_in,
    input  logic [ADDRESS_BITS-1:0] d_mem_address_in,
    input  logic                    d_mem_write,
    input  logic                    d_mem_read,
    input  logic [DATA_WIDTH-1:0]   d_mem_data_in,
    output logic [DATA_WIDTH-1:0]   read_data,
    output logic                    read_valid,
    output logic                    irq_request,
    output logic [3:0]              irq_vector,
    input  logic                    irq_ack,
    input  logic                    irq_done
);

    localparam logic [ADDRESS_BITS-1:0] ADDR_EICRA = BASE_ADDRESS + ADDRESS_BITS'(OFF_EICRA);
    localparam logic [ADDRESS_BITS-1:0] ADDR_EIFR  = BASE_ADDRESS + ADDRESS_BITS'(OFF_EIFR);
    localparam logic [ADDRESS_BITS-1:0] ADDR_EIMSK = BASE_ADDRESS + ADDRESS_BITS'(OFF_EIMSK);

    logic [NUM_CHANNELS-1:0]   filt, rise, fall;
    logic [NUM_CHANNELS-1:0]   eifr, eimsk;
    logic [2*NUM_CHANNELS-1:0] eicra;
    logic [NUM_CHANNELS-1:0]   pending, edge_set, eifr_clr;
    logic [3:0]                lowest;
    logic                      found;
    logic                      vec_pending;
    logic [DATA_WIDTH-1:0]     rdata;
    logic                      hit_eicra, hit_eifr, hit_eimsk;
    logic                      unused_data;
    state_e                    state, state_n;
    logic [3:0]                vector, vector_n;

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_pin
        int_pin_filter #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_filter (
            .clock   (clock),
            .reset   (reset),
            .pin     (pin_in[i]),
            .filtered(filt[i]),
            .rise    (rise[i]),
            .fall    (fall[i])
        );
    end

    assign hit_eicra   = (d_mem_address_in == ADDR_EICRA);
    assign hit_eifr    = (d_mem_address_in == ADDR_EIFR);
    assign hit_eimsk   = (d_mem_address_in == ADDR_EIMSK);
    assign unused_data = ^d_mem_data_in;

    always_comb begin
        pending     = '0;
        edge_set    = '0;
        eifr_clr    = '0;
        vec_pending = 1'b0;
        lowest      = '0;
        found       = 1'b0;
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            mode_e mode;
            mode = mode_e'(eicra[2*i +: 2]);
            if (mode == MODE_LOW) begin
                pending[i] = ~filt[i] & eimsk[i];
            end else begin
                pending[i]  = eifr[i] & eimsk[i];
                edge_set[i] = edge_match(mode, rise[i], fall[i]);
                if (state == ST_REQUEST && irq_ack && vector == 4'(i))
                    eifr_clr[i] = 1'b1;
            end
            if (d_mem_write && hit_eifr && d_mem_data_in[i])
                eifr_clr[i] = 1'b1;
            if (vector == 4'(i))
                vec_pending = pending[i];
            if (pending[i] && !found) begin
                lowest = 4'(i);
                found  = 1'b1;
            end
        end
    end

    // A flag set by a fresh edge outranks any clear landing on the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            eicra <= '0;
            eimsk <= '0;
            eifr  <= '0;
        end else begin
            if (d_mem_write && hit_eicra) eicra <= d_mem_data_in[2*NUM_CHANNELS-1:0];
            if (d_mem_write && hit_eimsk) eimsk <= d_mem_data_in[NUM_CHANNELS-1:0];
            eifr <= (eifr & ~eifr_clr) | edge_set;
        end
    end

    always_comb begin
        rdata = '0;
        if (hit_eicra) rdata = DATA_WIDTH'(eicra);
        if (hit_eifr)  rdata = DATA_WIDTH'(eifr);
        if (hit_eimsk) rdata = DATA_WIDTH'(eimsk);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            read_data  <= '0;
            read_valid <= 1'b0;
        end else begin
            read_valid <= d_mem_read;
            if (d_mem_read) read_data <= rdata;
        end
    end

    always_comb begin
        state_n  = state;
        vector_n = vector;
        case (state)
            ST_IDLE: begin
                if (|pending) begin
                    state_n  = ST_REQUEST;
                    vector_n = lowest;
                end
            end
            ST_REQUEST: begin
                if (irq_ack)           state_n = ST_IN_SERVICE;
                else if (!vec_pending) state_n = ST_IDLE;
            end
            ST_IN_SERVICE: begin
                if (irq_done) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= ST_IDLE;
            vector <= '0;
        end else begin
            state  <= state_n;
            vector <= vector_n;
        end
    end

    assign irq_request = (state == ST_REQUEST);
    assign irq_vector  = vector;

endmodule

// File: tb/tb_ext_int_controller.sv
// Directed bench for ext_int_controller: register table plus interrupt sequences.
module tb_ext_int_controller;

    localparam logic [31:0] A_EICRA = 32'h0000_206C;
    localparam logic [31:0] A_EIFR  = 32'h0000_2070;
    localparam logic [31:0] A_EIMSK = 32'h0000_2074;

    logic        clock;
    logic        reset;
    logic [1:0]  pin_in;
    logic [31:0] d_mem_address_in;
    logic        d_mem_write;
    logic        d_mem_read;
    logic [31:0] d_mem_data_in;
    logic [31:0] read_data;
    logic        read_valid;
    logic        irq_request;
    logic [3:0]  irq_vector;
    logic        irq_ack;
    logic        irq_done;

    int tests = 0;
    int fails = 0;

    ext_int_controller #(
        .NUM_CHANNELS   (2),
        .DATA_WIDTH     (32),
        .ADDRESS_BITS   (32),
        .BASE_ADDRESS   (32'h0000_206C),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .pin_in          (pin_in),
        .d_mem_address_in(d_mem_address_in),
        .d_mem_write     (d_mem_write),
        .d_mem_read      (d_mem_read),
        .d_mem_data_in   (d_mem_data_in),
        .read_data       (read_data),
        .read_valid      (read_valid),
        .irq_request     (irq_request),
        .irq_vector      (irq_vector),
        .irq_ack         (irq_ack),
        .irq_done        (irq_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        wr;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [31:0] raddr;
        logic [31:0] exp;
    } vec_t;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        d_mem_address_in = addr;
        d_mem_data_in    = data;
        d_mem_write      = 1'b1;
        tick();
        d_mem_write      = 1'b0;
    endtask

    task automatic bus_read(input string name, input logic [31:0] addr, input logic [31:0] exp);
        d_mem_address_in = addr;
        d_mem_read       = 1'b1;
        tick();
        d_mem_read       = 1'b0;
        check({name, "_valid"}, {31'b0, read_valid}, 32'd1);
        check(name, read_data, exp);
    endtask

    task automatic wait_req(input logic lvl, input int max, output int n);
        n = 0;
        while (irq_request !== lvl && n < max) begin
            tick();
            n++;
        end
    endtask

    task automatic pulse_ack();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    task automatic pulse_done();
        irq_done = 1'b1;
        tick();
        irq_done = 1'b0;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) tick();
    endtask

    vec_t table_v[11];
    int   n;

    initial begin
        table_v[0]  = '{1'b1, A_EICRA, 32'h0000_000A, A_EICRA, 32'h0000_000A};
        table_v[1]  = '{1'b1, A_EIMSK, 32'hFFFF_FFFF, A_EIMSK, 32'h0000_0003};
        table_v[2]  = '{1'b1, A_EICRA, 32'hFFFF_FFF5, A_EICRA, 32'h0000_0005};
        table_v[3]  = '{1'b0, A_EIFR,  32'h0,         A_EIFR,  32'h0};
        table_v[4]  = '{1'b1, A_EIFR,  32'hFFFF_FFFF, A_EIFR,  32'h0};
        table_v[5]  = '{1'b0, 32'h0,   32'h0,         32'h0000_2078, 32'h0};
        table_v[6]  = '{1'b0, 32'h0,   32'h0,         32'h0000_206D, 32'h0};
        table_v[7]  = '{1'b0, 32'h0,   32'h0,         32'h0001_206C, 32'h0};
        table_v[8]  = '{1'b1, 32'h0000_2078, 32'hFF,  A_EICRA, 32'h0000_0005};
        table_v[9]  = '{1'b1, A_EICRA, 32'h0,         A_EICRA, 32'h0};
        table_v[10] = '{1'b1, A_EIMSK, 32'h0,         A_EIMSK, 32'h0};

        reset = 1'b1;
        pin_in = 2'b11;
        d_mem_address_in = '0;
        d_mem_write = 1'b0;
        d_mem_read = 1'b0;
        d_mem_data_in = '0;
        irq_ack = 1'b0;
        irq_done = 1'b0;
        idle(3);
        reset = 1'b0;

        // Reset state
        check("rst_irq_request", {31'b0, irq_request}, 32'd0);
        check("rst_irq_vector", {28'b0, irq_vector}, 32'd0);
        check("rst_read_valid", {31'b0, read_valid}, 32'd0);
        bus_read("rst_eicra", A_EICRA, 32'h0);
        bus_read("rst_eifr", A_EIFR, 32'h0);
        bus_read("rst_eimsk", A_EIMSK, 32'h0);
        tick();
        check("read_valid_drops", {31'b0, read_valid}, 32'd0);

        // Register table
        for (int i = 0; i < 11; i++) begin
            if (table_v[i].wr) bus_write(table_v[i].waddr, table_v[i].wdata);
            bus_read($sformatf("table_%0d", i), table_v[i].raddr, table_v[i].exp);
        end

        // Falling edge on channel 0: 2 sync + 4 debounce + flag + FSM = 8 cycles
        bus_write(A_EICRA, 32'h2);
        bus_write(A_EIMSK, 32'h1);
        pin_in = 2'b10;
        wait_req(1'b1, 20, n);
        check("fall_latency", n, 32'd8);
        check("fall_vector", {28'b0, irq_vector}, 32'd0);
        bus_read("fall_eifr", A_EIFR, 32'h1);
        check("fall_still_req", {31'b0, irq_request}, 32'd1);
        pulse_ack();
        check("fall_ack_req", {31'b0, irq_request}, 32'd0);
        bus_read("fall_eifr_acked", A_EIFR, 32'h0);
        pulse_done();
        pin_in = 2'b11;
        idle(12);
        check("fall_release_idle", {31'b0, irq_request}, 32'd0);

        // 3-cycle glitch must be filtered out
        pin_in = 2'b10;
        idle(3);
        pin_in = 2'b11;
        idle(12);
        check("bounce_req", {31'b0, irq_request}, 32'd0);
        bus_read("bounce_eifr", A_EIFR, 32'h0);

        // Priority: both channels fall together
        bus_write(A_EICRA, 32'hA);
        bus_write(A_EIMSK, 32'h3);
        pin_in = 2'b00;
        wait_req(1'b1, 20, n);
        check("prio_latency", n, 32'd8);
        check("prio_vector0", {28'b0, irq_vector}, 32'd0);
        bus_read("prio_eifr", A_EIFR, 32'h3);
        pulse_ack();
        bus_read("prio_eifr_ack0", A_EIFR, 32'h2);
        check("prio_in_service", {31'b0, irq_request}, 32'd0);
        pulse_done();
        wait_req(1'b1, 5, n);
        check("prio_second_latency", n, 32'd1);
        check("prio_vector1", {28'b0, irq_vector}, 32'd1);
        pulse_ack();
        bus_read("prio_eifr_ack1", A_EIFR, 32'h0);
        pulse_done();
        pin_in = 2'b11;
        idle(12);
        check("prio_idle", {31'b0, irq_request}, 32'd0);

        // Level mode on channel 0
        bus_write(A_EICRA, 32'h0);
        bus_write(A_EIMSK, 32'h1);
        pin_in = 2'b10;
        wait_req(1'b1, 20, n);
        check("level_latency", n, 32'd7);
        check("level_vector", {28'b0, irq_vector}, 32'd0);
        pulse_ack();
        check("level_in_service", {31'b0, irq_request}, 32'd0);
        pulse_done();
        check("level_after_done", {31'b0, irq_request}, 32'd0);
        tick();
        check("level_reassert", {31'b0, irq_request}, 32'd1);
        pin_in = 2'b11;
        wait_req(1'b0, 20, n);
        check("level_release_drop", n, 32'd7);
        bus_read("level_eifr", A_EIFR, 32'h0);
        pulse_ack();
        pulse_done();
        idle(2);
        check("stray_ack_done", {31'b0, irq_request}, 32'd0);

        // Write-1-to-clear lands on the same edge that sets the flag
        bus_write(A_EICRA, 32'h2);
        bus_write(A_EIMSK, 32'h0);
        pin_in = 2'b10;
        idle(6);
        bus_write(A_EIFR, 32'h1);
        bus_read("race_eifr", A_EIFR, 32'h1);
        check("race_masked_req", {31'b0, irq_request}, 32'd0);
        bus_write(A_EIFR, 32'h1);
        bus_read("w1c_eifr", A_EIFR, 32'h0);
        pin_in = 2'b11;
        idle(12);

        // Reset during service with EIFR = 3
        bus_write(A_EICRA, 32'h9);
        bus_write(A_EIMSK, 32'h3);
        pin_in = 2'b00;
        wait_req(1'b1, 20, n);
        check("rstcase_latency", n, 32'd8);
        pulse_ack();
        pin_in = 2'b11;
        idle(10);
        bus_read("rstcase_eifr", A_EIFR, 32'h3);
        reset = 1'b1;
        tick();
        check("rstcase_req", {31'b0, irq_request}, 32'd0);
        reset = 1'b0;
        bus_read("rstcase_eicra", A_EICRA, 32'h0);
        bus_read("rstcase_eifr0", A_EIFR, 32'h0);
        bus_read("rstcase_eimsk", A_EIMSK, 32'h0);
        idle(20);
        check("rstcase_no_req", {31'b0, irq_request}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
